// File: rtl/bip_trace_pkg.sv
// Shared constants, FSM encoding and snapshot layout for the BIP trace transmitter.
package bip_trace_pkg;

   localparam logic [7:0] TRACE_HDR     = 8'hA5;
   localparam int         FRAME_BYTES   = 7;
   localparam int         BITS_PER_BYTE = 10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2,
      WAIT = 2'd3
   } trace_state_t;

   typedef struct packed {
      logic [15:0] pc;
      logic [15:0] inst;
      logic [15:0] acc;
   } trace_snap_t;

   function automatic logic [7:0] frame_byte(input trace_snap_t snap, input logic [2:0] idx);
      case (idx)
         3'd0:    return TRACE_HDR;
         3'd1:    return snap.pc[15:8];
         3'd2:    return snap.pc[7:0];
         3'd3:    return snap.inst[15:8];
         3'd4:    return snap.inst[7:0];
         3'd5:    return snap.acc[15:8];
         3'd6:    return snap.acc[7:0];
         default: return 8'hFF;
      endcase
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer, LSB first, BAUD_DIV cycles per bit.
// Latency: start bit drives the line in the i_start cycle when idle; o_done marks last stop cycle.
// Backpressure: i_start is ignored unless idle or in the o_done cycle.
module uart_tx_byte
   import bip_trace_pkg::*;
#(
   parameter int BAUD_DIV = 10417
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_start,
   input  logic [7:0] i_data,
   output logic       o_tx,
   output logic       o_done
);

   localparam int                 NB_BAUD   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [NB_BAUD-1:0] BAUD_LAST = NB_BAUD'(BAUD_DIV - 1);
   localparam logic [3:0]         BIT_LAST  = 4'(BITS_PER_BYTE - 1);

   // Starting from idle, the i_start cycle already counts as the first start-bit cycle.
   localparam logic [NB_BAUD-1:0] CNT_IDLE_START = (BAUD_DIV > 1) ? NB_BAUD'(1) : '0;
   localparam logic [3:0]         BIT_IDLE_START = (BAUD_DIV > 1) ? 4'd0 : 4'd1;

   logic               active;
   logic [NB_BAUD-1:0] baud_cnt;
   logic [3:0]         bit_idx;
   logic [9:0]         shreg;
   logic               bit_end;
   logic               load;

   assign bit_end = (baud_cnt == BAUD_LAST);
   assign o_done  = active && bit_end && (bit_idx == BIT_LAST);
   assign load    = i_start && (!active || o_done);
   assign o_tx    = (i_start && !active) ? 1'b0 : (active ? shreg[bit_idx] : 1'b1);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         active   <= 1'b0;
         baud_cnt <= '0;
         bit_idx  <= 4'd0;
         shreg    <= '1;
      end else if (load) begin
         shreg    <= {1'b1, i_data, 1'b0};
         active   <= 1'b1;
         baud_cnt <= active ? '0 : CNT_IDLE_START;
         bit_idx  <= active ? 4'd0 : BIT_IDLE_START;
      end else if (active) begin
         if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= bit_idx + 4'd1;
            if (bit_idx == BIT_LAST) begin
               active <= 1'b0;
            end
         end else begin
            baud_cnt <= baud_cnt + NB_BAUD'(1);
         end
      end
   end

endmodule

// File: rtl/bip_trace_tx.sv
// Snapshots pc/inst/acc on i_valid and sends a 7-byte trace frame on a UART line.
// Latency: start bit of byte 0 appears the cycle after the accepted strobe; frame is 70*BAUD_DIV cycles.
// Backpressure: none upstream; strobes while o_busy is high are dropped and counted (saturating).
module bip_trace_tx
   import bip_trace_pkg::*;
#(
   parameter int NB_BITS  = 16,
   parameter int NB_PC    = 11,
   parameter int BAUD_DIV = 10417
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_valid,
   input  logic [NB_PC-1:0]   i_pc,
   input  logic [NB_BITS-1:0] i_inst,
   input  logic [NB_BITS-1:0] i_acc,
   output logic               o_tx,
   output logic               o_busy,
   output logic [7:0]         o_drop_cnt
);

   localparam logic [2:0] LAST_BYTE = 3'(FRAME_BYTES - 1);

   trace_state_t state, state_nxt;
   logic [2:0]   byte_idx, byte_idx_nxt;
   trace_snap_t  snap;
   logic         capture;
   logic         ser_start;
   logic         ser_done;
   logic [7:0]   ser_data;

   always_comb begin
      state_nxt    = state;
      byte_idx_nxt = byte_idx;
      capture      = 1'b0;
      ser_start    = 1'b0;
      case (state)
         IDLE: begin
            if (i_valid) begin
               capture      = 1'b1;
               byte_idx_nxt = 3'd0;
               state_nxt    = LOAD;
            end
         end
         LOAD: begin
            ser_start = 1'b1;
            state_nxt = SEND;
         end
         SEND: begin
            if (ser_done) begin
               if (byte_idx == LAST_BYTE) begin
                  state_nxt = IDLE;
               end else begin
                  byte_idx_nxt = byte_idx + 3'd1;
                  state_nxt    = LOAD;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // o_busy is registered, so a strobe in the final SEND cycle still counts as a drop.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= IDLE;
         byte_idx   <= 3'd0;
         o_busy     <= 1'b0;
         snap       <= '0;
         o_drop_cnt <= 8'd0;
      end else begin
         state    <= state_nxt;
         byte_idx <= byte_idx_nxt;
         o_busy   <= (state_nxt != IDLE);
         if (capture) begin
            snap.pc   <= 16'(i_pc);
            snap.inst <= 16'(i_inst);
            snap.acc  <= 16'(i_acc);
         end
         if (i_valid && o_busy && (o_drop_cnt != 8'hFF)) begin
            o_drop_cnt <= o_drop_cnt + 8'd1;
         end
      end
   end

   assign ser_data = frame_byte(snap, byte_idx);

   uart_tx_byte #(
      .BAUD_DIV (BAUD_DIV)
   ) u_ser (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_start (ser_start),
      .i_data  (ser_data),
      .o_tx    (o_tx),
      .o_done  (ser_done)
   );

endmodule
